ap: RTL and testbench
=====================

AP -- requirements
Module: ap

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Port clk  input  1  rising-edge clock for all sequential logic.
REQ-003 Port rst  input  1  asynchronous active-low reset.
REQ-004 Port ap_mode  input  1  0 = memory mode (host read/write); 1 = request/hold an associative operation.
REQ-005 Port cmd  input  3  operation select, sampled on AP start.
REQ-006 Port sel_col  input  1  column select for host access: 0 = column A, 1 = column B.
REQ-007 Port write_en  input  1  1 = write data into the selected column at addr; 0 = read.
REQ-008 Port data  input  8  host write data.
REQ-009 Port addr  input  10  row address, 0..1023.
REQ-010 Port data_out  output  8  registered host read data.
REQ-011 Port ap_state_irq  output  1  operation-complete flag.

Function
REQ-012 Storage SHALL be two columns, A and B, each 1024 rows x 8 bits; rows are never reset.
REQ-013 Memory mode (state IDLE, ap_mode=0), write_en=1: at the clock edge, write data to A[addr] (sel_col=0) or B[addr] (sel_col=1); data_out holds.
REQ-014 Memory mode, write_en=0: at the clock edge, data_out <= selected column[addr], giving 1-cycle read latency.
REQ-015 Host writes and reads SHALL be ignored outside IDLE or while ap_mode=1; data_out holds its value.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE with ap_mode=1 SHALL latch cmd, clear the bit counter to 0, initialise the per-row carry, and enter RUN on the next edge.
REQ-018 RUN SHALL last exactly 8 cycles; in cycle k (k = 0..7), bit k of every row SHALL be computed in parallel and written into A[row] bit k.
REQ-019 After bit 7, the FSM SHALL enter DONE.
REQ-020 In DONE, ap_state_irq=1; it SHALL stay 1 while ap_mode=1.
REQ-021 When ap_mode=0 in DONE, the FSM SHALL return to IDLE and ap_state_irq SHALL go to 0 on that edge.
REQ-022 ap_state_irq SHALL be 0 in IDLE and RUN.
REQ-023 The operation sets A <= f(A, B) for all 1024 rows, with B unchanged; cmd encoding:
- 0 ADD: A+B mod 256
- 1 SUB: A-B mod 256, computed as A + ~B + 1
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT A
- 6 NOR
- 7 XNOR
REQ-024 ADD/SUB SHALL keep a 1-bit carry per row, initialised to 0 (ADD) or 1 (SUB) on entering RUN; the carry out of bit 7 is discarded.
REQ-025 A change on cmd during RUN/DONE SHALL have no effect; the latched cmd is used.
REQ-026 ap_mode falling during RUN SHALL NOT abort; the FSM completes RUN, passes through DONE for one cycle with irq=1, then returns to IDLE.
REQ-027 Operation latency: start edge to ap_state_irq=1 is 9 clock edges (1 start + 8 bit cycles).

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, bit counter=0, carries=0, data_out=8'h00, ap_state_irq=0.
REQ-029 Reset during RUN SHALL abandon the operation; already-written low bits of A remain, and no irq is raised.
REQ-030 After rst returns to 1, the block SHALL be in memory mode; a new operation requires ap_mode=1 in IDLE.

Verification
REQ-031 Write A[0]=1 (sel_col=0), B[0]=1 (sel_col=1), then read sel_col=1, addr 0 -> data_out=8'h01 one cycle after the read edge.
REQ-032 A[0]=1, B[0]=1, cmd=0, ap_mode=1 -> irq=1 after 9 edges and held while ap_mode=1; after ap_mode=0, reading A[0] gives 8'h02 and B[0] gives 8'h01.
REQ-033 A[5]=8'h05, B[5]=8'h07, cmd=1 -> A[5]=8'hFE; A[6]=8'hFF, B[6]=8'h01, cmd=0 -> A[6]=8'h00 (wrap).
REQ-034 A[3]=8'hF0, B[3]=8'h3C with cmd=2 / 4 / 5 -> A[3]=8'h30 / 8'hCC / 8'h0F respectively, each run started from fresh A[3].
REQ-035 write_en=1, data=8'hAA, addr 9 during RUN -> A[9]/B[9] unchanged after completion; irq timing unaffected.
REQ-036 Assert rst=0 in RUN cycle 3 -> irq=0 and data_out=0 at once; after release, idle memory-mode read/write works normally.

Source files
------------

// File: rtl/ap.sv
// ---------------------------------------------------------------------------
// ap : two-column 1024x8 associative processor, bit-serial A <= f(A,B)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ap (
  input  logic       clk,
  input  logic       rst,
  input  logic       ap_mode,
  input  logic [2:0] cmd,
  input  logic       sel_col,
  input  logic       write_en,
  input  logic [7:0] data,
  input  logic [9:0] addr,
  output logic [7:0] data_out,
  output logic       ap_state_irq
);

  localparam int ROWS = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [2:0]      bit_q, bit_d;
  logic [ROWS-1:0] carry_q, carry_d;
  logic [7:0]      data_out_q, data_out_d;

  logic [7:0]      mem_a [ROWS];
  logic [7:0]      mem_b [ROWS];

  logic [ROWS-1:0] bit_new;
  logic [ROWS-1:0] carry_next;
  logic            host_ok;

  assign host_ok = (state_q == IDLE) && !ap_mode;

  // Per-row bit slice for the current RUN cycle; SUB is A + ~B with carry-in 1.
  always_comb begin
    bit_new    = '0;
    carry_next = carry_q;
    for (int r = 0; r < ROWS; r++) begin
      logic a, b, bb;
      a  = mem_a[r][bit_q];
      b  = mem_b[r][bit_q];
      bb = (cmd_q == 3'd1) ? ~b : b;
      case (cmd_q)
        3'd0, 3'd1: begin
          bit_new[r]    = a ^ bb ^ carry_q[r];
          carry_next[r] = (a & bb) | (carry_q[r] & (a ^ bb));
        end
        3'd2:    bit_new[r] = a & b;
        3'd3:    bit_new[r] = a | b;
        3'd4:    bit_new[r] = a ^ b;
        3'd5:    bit_new[r] = ~a;
        3'd6:    bit_new[r] = ~(a | b);
        default: bit_new[r] = ~(a ^ b);
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    bit_d      = bit_q;
    carry_d    = carry_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (ap_mode) begin
          cmd_d   = cmd;
          bit_d   = 3'd0;
          carry_d = {ROWS{cmd == 3'd1}};
          state_d = RUN;
        end else if (!write_en) begin
          data_out_d = sel_col ? mem_b[addr] : mem_a[addr];
        end
      end
      RUN: begin
        bit_d   = bit_q + 3'd1;
        carry_d = carry_next;
        if (bit_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        if (!ap_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_q      <= 3'd0;
      bit_q      <= 3'd0;
      carry_q    <= '0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bit_q      <= bit_d;
      carry_q    <= carry_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage rows carry no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (rst && host_ok && write_en) begin
      if (sel_col) mem_b[addr] <= data;
      else         mem_a[addr] <= data;
    end else if (state_q == RUN) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_a[r][bit_q] <= bit_new[r];
      end
    end
  end

  assign data_out     = data_out_q;
  assign ap_state_irq = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_ap.sv
// ---------------------------------------------------------------------------
// tb_ap : directed table-driven bench for ap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ap;

  logic       clk = 1'b0;
  logic       rst;
  logic       ap_mode;
  logic [2:0] cmd;
  logic       sel_col;
  logic       write_en;
  logic [7:0] data;
  logic [9:0] addr;
  logic [7:0] data_out;
  logic       ap_state_irq;

  int errors = 0;
  int checks = 0;

  ap dut (
    .clk          (clk),
    .rst          (rst),
    .ap_mode      (ap_mode),
    .cmd          (cmd),
    .sel_col      (sel_col),
    .write_en     (write_en),
    .data         (data),
    .addr         (addr),
    .data_out     (data_out),
    .ap_state_irq (ap_state_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       col;
    logic       we;
    logic [7:0] d;
    logic [9:0] a;
    logic [7:0] exp;
  } host_vec_t;

  typedef struct {
    logic [2:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } op_vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic col, input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    ap_mode  = 1'b0;
    sel_col  = col;
    write_en = 1'b1;
    addr     = a;
    data     = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic host_read(input logic col, input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    ap_mode  = 1'b0;
    sel_col  = col;
    write_en = 1'b0;
    addr     = a;
    @(posedge clk);
    #1;
    d = data_out;
  endtask

  // Starts an operation and counts edges until irq; optionally drops ap_mode
  // after edge 3 or scribbles cmd/host inputs while the operation runs.
  task automatic run_op(input logic [2:0] c, input bit drop, input bit disturb, input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    ap_mode = 1'b1;
    cmd     = c;
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (ap_state_irq) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        if (disturb && n >= 2) begin
          cmd      = c ^ n[2:0] ^ 3'd1;
          write_en = 1'b1;
          data     = 8'hAA;
          addr     = 10'd9;
          sel_col  = n[0];
        end
        if (drop && n == 3) ap_mode = 1'b0;
      end
    end
    @(negedge clk);
    write_en = 1'b0;
    check({name, " latency"}, 8'(n), 8'd9);
    if (drop) begin
      @(posedge clk);
      #1;
      check({name, " irq clear after drop"}, {7'd0, ap_state_irq}, 8'd0);
    end else begin
      repeat (2) begin
        @(posedge clk);
        #1;
        check({name, " irq held"}, {7'd0, ap_state_irq}, 8'd1);
      end
      @(negedge clk);
      ap_mode = 1'b0;
      @(posedge clk);
      #1;
      check({name, " irq clear"}, {7'd0, ap_state_irq}, 8'd0);
    end
  endtask

  host_vec_t hv[11];
  op_vec_t   ov[10];

  initial begin
    logic [7:0] rd;

    hv[0]  = '{1'b0, 1'b1, 8'h01, 10'd0,    8'h00};
    hv[1]  = '{1'b1, 1'b1, 8'h01, 10'd0,    8'h00};
    hv[2]  = '{1'b1, 1'b0, 8'h00, 10'd0,    8'h01};
    hv[3]  = '{1'b0, 1'b0, 8'h00, 10'd0,    8'h01};
    hv[4]  = '{1'b0, 1'b1, 8'h5A, 10'd1023, 8'h01};
    hv[5]  = '{1'b1, 1'b1, 8'hC3, 10'd1023, 8'h01};
    hv[6]  = '{1'b0, 1'b0, 8'h00, 10'd1023, 8'h5A};
    hv[7]  = '{1'b1, 1'b0, 8'h00, 10'd1023, 8'hC3};
    hv[8]  = '{1'b0, 1'b1, 8'hFF, 10'd512,  8'hC3};
    hv[9]  = '{1'b0, 1'b0, 8'h00, 10'd512,  8'hFF};
    hv[10] = '{1'b1, 1'b0, 8'h00, 10'd1023, 8'hC3};

    ov[0] = '{3'd2, 8'hF0, 8'h3C, 8'h30};
    ov[1] = '{3'd3, 8'hF0, 8'h3C, 8'hFC};
    ov[2] = '{3'd4, 8'hF0, 8'h3C, 8'hCC};
    ov[3] = '{3'd5, 8'hF0, 8'h3C, 8'h0F};
    ov[4] = '{3'd6, 8'hF0, 8'h3C, 8'h03};
    ov[5] = '{3'd7, 8'hF0, 8'h3C, 8'h33};
    ov[6] = '{3'd0, 8'hFF, 8'h01, 8'h00};
    ov[7] = '{3'd1, 8'h05, 8'h07, 8'hFE};
    ov[8] = '{3'd1, 8'h00, 8'h01, 8'hFF};
    ov[9] = '{3'd0, 8'h80, 8'h80, 8'h00};

    rst = 1'b0; ap_mode = 1'b0; cmd = 3'd0; sel_col = 1'b0;
    write_en = 1'b0; data = 8'h00; addr = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", data_out, 8'h00);
    check("reset irq", {7'd0, ap_state_irq}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // Host memory-mode table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      sel_col  = hv[i].col;
      write_en = hv[i].we;
      data     = hv[i].d;
      addr     = hv[i].a;
      @(posedge clk);
      #1;
      check($sformatf("host vec %0d", i), data_out, hv[i].exp);
    end
    @(negedge clk);
    write_en = 1'b0;

    // ADD 1+1, plus row 1023 riding along
    run_op(3'd0, 1'b0, 1'b0, "add0");
    host_read(1'b0, 10'd0, rd);    check("add A[0]", rd, 8'h02);
    host_read(1'b1, 10'd0, rd);    check("add B[0]", rd, 8'h01);
    host_read(1'b0, 10'd1023, rd); check("add A[1023]", rd, 8'h1D);

    // SUB then ADD with wrap on rows 5/6
    host_write(1'b0, 10'd5, 8'h05);
    host_write(1'b1, 10'd5, 8'h07);
    host_write(1'b0, 10'd6, 8'hFF);
    host_write(1'b1, 10'd6, 8'h01);
    run_op(3'd1, 1'b0, 1'b0, "sub5");
    host_read(1'b0, 10'd5, rd);    check("sub A[5]", rd, 8'hFE);
    host_write(1'b0, 10'd6, 8'hFF);
    run_op(3'd0, 1'b0, 1'b0, "add6");
    host_read(1'b0, 10'd6, rd);    check("wrap A[6]", rd, 8'h00);
    host_read(1'b0, 10'd5, rd);    check("add A[5]", rd, 8'h05);

    // Operation table on row 3
    for (int i = 0; i < 10; i++) begin
      host_write(1'b0, 10'd3, ov[i].a);
      host_write(1'b1, 10'd3, ov[i].b);
      run_op(ov[i].c, 1'b0, 1'b0, $sformatf("op %0d", i));
      host_read(1'b0, 10'd3, rd); check($sformatf("op %0d A[3]", i), rd, ov[i].exp);
      host_read(1'b1, 10'd3, rd); check($sformatf("op %0d B[3]", i), rd, ov[i].b);
    end

    // cmd and host inputs toggled during RUN are ignored
    host_write(1'b0, 10'd9, 8'h11);
    host_write(1'b1, 10'd9, 8'h22);
    run_op(3'd3, 1'b0, 1'b1, "disturb");
    host_read(1'b0, 10'd9, rd); check("disturb A[9]", rd, 8'h33);
    host_read(1'b1, 10'd9, rd); check("disturb B[9]", rd, 8'h22);

    // ap_mode dropped mid-RUN still completes
    host_write(1'b0, 10'd4, 8'h0C);
    host_write(1'b1, 10'd4, 8'h0A);
    run_op(3'd2, 1'b1, 1'b0, "drop");
    host_read(1'b0, 10'd4, rd); check("drop A[4]", rd, 8'h08);

    // Reset in RUN cycle 3: bits 0..2 already written
    host_write(1'b0, 10'd7, 8'h00);
    host_write(1'b1, 10'd7, 8'hFF);
    host_read(1'b1, 10'd7, rd); check("pre-reset read", rd, 8'hFF);
    @(negedge clk);
    ap_mode = 1'b1;
    cmd     = 3'd4;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    ap_mode = 1'b0;
    #1;
    check("rst irq", {7'd0, ap_state_irq}, 8'd0);
    check("rst data_out", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("post-rst irq", {7'd0, ap_state_irq}, 8'd0);
    end
    host_read(1'b0, 10'd7, rd); check("rst partial A[7]", rd, 8'h07);
    host_write(1'b1, 10'd8, 8'h5C);
    host_read(1'b1, 10'd8, rd); check("post-rst rw", rd, 8'h5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
